// File: rtl/subtractor_nbit_seq.sv
// Multi-cycle WIDTH-bit subtractor: Diff = A - B - Bin, CHUNK bits per clock through
// a ripple of adder_1bit cells (B inverted, carry-in = ~borrow), borrow registered between chunks.

module adder_1bit #(
   parameter int IMPL_TYPE = 0
) (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   generate
      if (IMPL_TYPE == 0) begin : g_gate
         assign s    = a ^ b ^ cin;
         assign cout = (a & b) | (cin & (a ^ b));
      end else begin : g_arith
         assign {cout, s} = 2'(a) + 2'(b) + 2'(cin);
      end
   endgenerate
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for in_valid; Diff holds the last result
// BUSY  | one CHUNK slice per edge, borrow carried in borrow_reg
// DONE  | out_valid high, result and flags held until out_ready
module subtractor_nbit_seq #(
   parameter int WIDTH     = 32,
   parameter int CHUNK     = 8,
   parameter int IMPL_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Zero,
   output logic             Ovf
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             borrow_reg;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK-1:0] sum_slice;
   logic [CHUNK:0]   carry;
   logic [WIDTH-1:0] diff_full;

   // diff_full is the Diff register with the current slice merged in, so the
   // flags on the last edge see the complete result rather than a stale slice.
   always_comb begin
      a_slice   = a_reg[int'(idx)*CHUNK +: CHUNK];
      b_slice   = b_reg[int'(idx)*CHUNK +: CHUNK];
      diff_full = Diff;
      diff_full[int'(idx)*CHUNK +: CHUNK] = sum_slice;
   end

   assign carry[0] = ~borrow_reg;

   generate
      for (genvar i = 0; i < CHUNK; i++) begin : g_chain
         adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
            .a    (a_slice[i]),
            .b    (~b_slice[i]),
            .cin  (carry[i]),
            .s    (sum_slice[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         borrow_reg <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         Diff       <= '0;
         Bout       <= 1'b0;
         Zero       <= 1'b0;
         Ovf        <= 1'b0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_reg      <= A;
                  b_reg      <= B;
                  borrow_reg <= Bin;
                  idx        <= '0;
                  in_ready   <= 1'b0;
                  state      <= S_BUSY;
               end
            end
            S_BUSY: begin
               Diff       <= diff_full;
               borrow_reg <= ~carry[CHUNK];
               idx        <= idx + IW'(1);
               if (idx == LAST_IDX) begin
                  Bout      <= ~carry[CHUNK];
                  Zero      <= (diff_full == '0);
                  Ovf       <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                               (a_reg[WIDTH-1] ^ diff_full[WIDTH-1]);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/subtractor_nbit_seq.md
Name: subtractor_nbit_seq

Overview:
- Multi-cycle n-bit subtractor. Computes Diff = A - B - Bin, CHUNK bits per clock, using a registered borrow between chunks.
- Built from the team's 1-bit full-adder cells with B inverted and carry-in = ~Bin. It is the subtract counterpart of adder_nbit.
- Sits in the FP datapath for exponent difference and mantissa subtraction, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK.
- IMPL_TYPE, 0, implementation select forwarded to every adder_1bit instance.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH
- Bout  output  1  borrow out; 1 when unsigned A < B + Bin
- Zero  output  1  Diff == 0
- Ovf  output  1  signed overflow: (A[msb]^B[msb]) & (A[msb]^Diff[msb])

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n low at a rising edge) forces:
  - state=IDLE, chunk index=0, borrow reg=0;
  - out_valid=0, Diff=0, Bout=0, Zero=0, Ovf=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the operation; the partial result is discarded and out_valid is never raised for it.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0. If in_valid at an edge:
    - capture A, B into internal regs;
    - borrow reg <= Bin, index <= 0;
    - go to BUSY.
  - BUSY: in_ready=0. Each edge:
    - computes slice [index*CHUNK +: CHUNK] as A_slice + ~B_slice + ~borrow through a CHUNK-bit adder_1bit chain;
    - writes that slice of the Diff reg;
    - borrow reg <= ~carry_out, index++.
    - After the edge that processes index NCHUNK-1: Bout <= final borrow, Zero and Ovf computed from the complete result, state=DONE.
  - DONE: out_valid=1, in_ready=0. Diff, Bout, Zero, Ovf held stable. When out_ready is high at an edge, go to IDLE and drop out_valid.
- Latency: acceptance at edge E0. out_valid is high starting right after edge E(NCHUNK); NCHUNK=4 at defaults.
- Throughput: at most one op per NCHUNK+2 cycles. The next accept happens at the earliest one edge after the output handshake.
- No input/output overlap: in_valid is ignored outside IDLE. Inputs that change after acceptance do not affect the result.
- Diff keeps its last result in IDLE. The Diff register may update slice-by-slice in BUSY; consumers qualify it with out_valid only.
- Flags are valid only with out_valid. They are computed from the full-width result, not per chunk.
- CHUNK==WIDTH is legal: a single BUSY cycle.

Test Plan (WIDTH=32, CHUNK=8):
- Reset: hold rst_n=0 for 2 edges with in_valid=1.
  - Expect in_ready=1, out_valid=0, Diff=0, Bout=0, Zero=0, Ovf=0.
  - Expect no operation accepted.
- Basic: A=0x00000005, B=0x00000003, Bin=0.
  - Expect out_valid 4 cycles after accept with Diff=0x00000002, Bout=0, Zero=0, Ovf=0.
  - Expect in_ready=0 throughout BUSY/DONE.
- Full borrow ripple: A=0x00000000, B=0x00000001, Bin=0.
  - Expect Diff=0xFFFFFFFF, Bout=1, Ovf=0.
  - Then A=0x00000100, B=0x000000FF, Bin=1: expect Diff=0x00000000, Zero=1, Bout=0.
- Signed overflow: A=0x80000000, B=0x00000001, Bin=0.
  - Expect Diff=0x7FFFFFFF, Ovf=1, Bout=0.
  - Then A=0x7FFFFFFF, B=0xFFFFFFFF: expect Diff=0x80000000, Ovf=1, Bout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Expect outputs stable, in_ready=0, and no new operands captured.
  - Raise out_ready: expect IDLE on the next edge, then the new operands accepted.
- Reset mid-op: assert rst_n=0 after 2 BUSY edges.
  - Expect IDLE, out_valid=0, Diff=0.
  - A following op A=10, B=4 must yield Diff=6 with correct 4-cycle latency.
